// File: rtl/inst_fetch_port_if.sv
// Byte-wide instruction memory read bus used by inst_fetch_port.
interface inst_fetch_port_if #(
  parameter int unsigned MEM_AW = 32
);
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/inst_fetch_port.sv
// IF-stage fetch responder: assembles a little-endian word from four byte reads.
// Optional next-word prefetch buffer enabled by macro INST_FETCH_PREFETCH_EN.
module inst_fetch_port #(
  parameter int unsigned MEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               ce,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid,
  output logic               inst_misaligned,
  output logic               stallreq,
  inst_fetch_port_if.master  mem
);

`ifdef INST_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StFetch, StPref} state_e;
  logic [31:0] pbuf;
  logic        pbuf_valid;
  logic        pbuf_hit;
`else
  typedef enum logic [1:0] {StIdle, StFetch} state_e;
`endif

  state_e      state;
  logic [31:0] req_pc;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic        hit;
  logic        new_fetch;
  logic [31:0] next_pc;
  logic [31:0] word;

  function automatic logic [MEM_AW-1:0] byte_addr(input logic [31:0] a, input logic [1:0] b);
    logic [31:0] full;
    full = {a[31:2], b};
    return full[MEM_AW-1:0];
  endfunction

  assign hit             = inst_valid && (pc == inst_pc);
  assign inst_misaligned = ce && (pc[1:0] != 2'b00);
  assign stallreq        = ce && !hit && !inst_misaligned;
  assign next_pc         = req_pc + 32'd4;
  assign word            = {mem.mem_rdata, asm_word[23:0]};

`ifdef INST_FETCH_PREFETCH_EN
  assign pbuf_hit = (state == StIdle) && pbuf_valid && (pc == req_pc) && !hit;
`endif

  // A new demand fetch (fresh miss or redirect) restarts from byte 0 of pc.
  always_comb begin
    new_fetch = 1'b0;
    unique case (state)
`ifdef INST_FETCH_PREFETCH_EN
      StIdle:  new_fetch = !hit && !pbuf_hit;
      StPref:  new_fetch = (pc != req_pc) && (pc != inst_pc);
`else
      StIdle:  new_fetch = !hit;
`endif
      StFetch: new_fetch = (pc != req_pc);
      default: new_fetch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      req_pc       <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_valid   <= 1'b0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
`ifdef INST_FETCH_PREFETCH_EN
      pbuf         <= '0;
      pbuf_valid   <= 1'b0;
`endif
    end else if (!ce) begin
      state      <= StIdle;
      inst_valid <= 1'b0;
      inst       <= '0;
      mem.mem_rd <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pbuf_valid <= 1'b0;
`endif
    end else if (inst_misaligned) begin
      // No fetch for a misaligned pc; the trap is raised downstream.
      state      <= StIdle;
      inst_valid <= 1'b0;
      mem.mem_rd <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pbuf_valid <= 1'b0;
`endif
    end else if (new_fetch) begin
      state        <= StFetch;
      req_pc       <= pc;
      byte_cnt     <= 2'd0;
      inst_valid   <= 1'b0;
      mem.mem_rd   <= 1'b1;
      mem.mem_addr <= byte_addr(pc, 2'd0);
`ifdef INST_FETCH_PREFETCH_EN
      pbuf_valid   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
`ifdef INST_FETCH_PREFETCH_EN
          if (pbuf_hit) begin
            inst         <= pbuf;
            inst_pc      <= req_pc;
            inst_valid   <= 1'b1;
            pbuf_valid   <= 1'b0;
            req_pc       <= next_pc;
            byte_cnt     <= 2'd0;
            mem.mem_rd   <= 1'b1;
            mem.mem_addr <= byte_addr(next_pc, 2'd0);
            state        <= StPref;
          end
`endif
        end
        StFetch: begin
          if (mem.mem_ready) begin
            asm_word[8*byte_cnt +: 8] <= mem.mem_rdata;
            if (byte_cnt == 2'd3) begin
              inst       <= word;
              inst_pc    <= req_pc;
              inst_valid <= 1'b1;
`ifdef INST_FETCH_PREFETCH_EN
              req_pc       <= next_pc;
              byte_cnt     <= 2'd0;
              mem.mem_addr <= byte_addr(next_pc, 2'd0);
              state        <= StPref;
`else
              mem.mem_rd <= 1'b0;
              state      <= StIdle;
`endif
            end else begin
              byte_cnt     <= byte_cnt + 2'd1;
              mem.mem_addr <= byte_addr(req_pc, byte_cnt + 2'd1);
            end
          end
        end
`ifdef INST_FETCH_PREFETCH_EN
        StPref: begin
          if (mem.mem_ready) begin
            asm_word[8*byte_cnt +: 8] <= mem.mem_rdata;
            if (byte_cnt == 2'd3) begin
              if (pc == req_pc) begin
                // Prefetch turned into the demand fetch: deliver and run ahead again.
                inst         <= word;
                inst_pc      <= req_pc;
                inst_valid   <= 1'b1;
                req_pc       <= next_pc;
                byte_cnt     <= 2'd0;
                mem.mem_addr <= byte_addr(next_pc, 2'd0);
              end else begin
                pbuf       <= word;
                pbuf_valid <= 1'b1;
                mem.mem_rd <= 1'b0;
                state      <= StIdle;
              end
            end else begin
              byte_cnt     <= byte_cnt + 2'd1;
              mem.mem_addr <= byte_addr(req_pc, byte_cnt + 2'd1);
            end
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Self-checking bench for inst_fetch_port against a byte-array memory model.
module tb_inst_fetch_port;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_misaligned;
  logic        stallreq;

  inst_fetch_port_if #(.MEM_AW(32)) mem_bus ();

  logic [7:0]  mem [256];
  logic [31:0] addrs [$];
  logic [31:0] stall_addr;
  int          stall_left = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign mem_bus.mem_rdata = mem[mem_bus.mem_addr[7:0]];

  inst_fetch_port #(.MEM_AW(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .ce              (ce),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .inst_misaligned (inst_misaligned),
    .stallreq        (stallreq),
    .mem             (mem_bus)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[8'(a + 32'd3)], mem[8'(a + 32'd2)], mem[8'(a + 32'd1)], mem[a[7:0]]};
  endfunction

  // Drives pc for up to 80 cycles until the word for a is valid; cycle 0 is the request cycle.
  task automatic run_fetch(input logic [31:0] a, input int wait_pct,
                           output int lat, output int waits, output int stalls);
    lat = -1;
    waits = 0;
    stalls = 0;
    addrs.delete();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      pc = a;
      ce = 1'b1;
      if (stall_left > 0 && mem_bus.mem_addr == stall_addr) begin
        mem_bus.mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_bus.mem_ready = ($urandom_range(99) >= wait_pct);
      end
      #1;
      if (inst_valid && inst_pc == a) begin
        lat = c;
        break;
      end
      if (stallreq) stalls++;
      if (c > 0 && mem_bus.mem_rd) begin
        if (mem_bus.mem_ready) addrs.push_back(mem_bus.mem_addr);
        else waits++;
      end
    end
    mem_bus.mem_ready = 1'b1;
  endtask

  task automatic drop_ce(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0;
      mem_bus.mem_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce = 1'b0;
    pc = 32'h0;
    mem_bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (inst !== 32'h0) begin n_errors++;
      $display("FAIL reset_inst got=%h want=0", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_errors++;
      $display("FAIL reset_inst_pc got=%h want=0", inst_pc); end
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    n_checks++; if (mem_bus.mem_rd !== 1'b0) begin n_errors++;
      $display("FAIL reset_mem_rd got=%b want=0", mem_bus.mem_rd); end
    n_checks++; if (mem_bus.mem_addr !== 32'h0) begin n_errors++;
      $display("FAIL reset_mem_addr got=%h want=0", mem_bus.mem_addr); end
    n_checks++; if (stallreq !== 1'b0) begin n_errors++;
      $display("FAIL reset_stallreq got=%b want=0", stallreq); end
  endtask

  task automatic test_basic();
    int lat, waits, stalls;
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    run_fetch(32'h0, 0, lat, waits, stalls);
    n_checks++; if (lat !== 5) begin n_errors++;
      $display("FAIL basic_latency got=%0d want=5", lat); end
    n_checks++; if (stalls !== 5) begin n_errors++;
      $display("FAIL basic_stall_cycles got=%0d want=5", stalls); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_errors++;
      $display("FAIL basic_inst got=%h want=00000013", inst); end
    n_checks++; if (stallreq !== 1'b0) begin n_errors++;
      $display("FAIL basic_hit_stall got=%b want=0", stallreq); end
    n_checks++; if (addrs.size() !== 4) begin n_errors++;
      $display("FAIL basic_nreads got=%0d want=4", addrs.size()); end
    for (int k = 0; k < addrs.size() && k < 4; k++) begin
      n_checks++; if (addrs[k] !== 32'(k)) begin n_errors++;
        $display("FAIL basic_addr[%0d] got=%h want=%h", k, addrs[k], k); end
    end
  endtask

  task automatic test_wait_states();
    int lat, waits, stalls;
    drop_ce(1);
    stall_addr = 32'h2;
    stall_left = 2;
    run_fetch(32'h0, 0, lat, waits, stalls);
    n_checks++; if (lat !== 7) begin n_errors++;
      $display("FAIL wait_latency got=%0d want=7", lat); end
    n_checks++; if (waits !== 2) begin n_errors++;
      $display("FAIL wait_held_addr got=%0d want=2", waits); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_errors++;
      $display("FAIL wait_inst got=%h want=00000013", inst); end
    for (int k = 0; k < addrs.size(); k++) begin
      n_checks++; if (addrs[k] !== 32'(k)) begin n_errors++;
        $display("FAIL wait_addr[%0d] got=%h want=%h", k, addrs[k], k); end
    end
  endtask

  task automatic test_redirect();
    int lat, waits, stalls;
    drop_ce(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pc = 32'h10;
      ce = 1'b1;
      mem_bus.mem_ready = 1'b1;
      #1;
      n_checks++; if (inst_valid && inst_pc == 32'h10) begin n_errors++;
        $display("FAIL redirect_old_valid got=1 want=0"); end
    end
    run_fetch(32'h40, 0, lat, waits, stalls);
    n_checks++; if (lat !== 5) begin n_errors++;
      $display("FAIL redirect_latency got=%0d want=5", lat); end
    n_checks++; if (inst !== word_at(32'h40)) begin n_errors++;
      $display("FAIL redirect_inst got=%h want=%h", inst, word_at(32'h40)); end
    n_checks++; if (addrs.size() !== 4) begin n_errors++;
      $display("FAIL redirect_nreads got=%0d want=4", addrs.size()); end
    for (int k = 0; k < addrs.size(); k++) begin
      n_checks++; if (addrs[k] !== 32'h40 + 32'(k)) begin n_errors++;
        $display("FAIL redirect_addr[%0d] got=%h want=%h", k, addrs[k], 32'h40 + k); end
    end
  endtask

  task automatic test_ce_drop();
    int lat, waits, stalls;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      pc = 32'h0;
      ce = 1'b1;
      mem_bus.mem_ready = 1'b1;
    end
    @(negedge clk);
    ce = 1'b0;
    #1;
    n_checks++; if (stallreq !== 1'b0) begin n_errors++;
      $display("FAIL cedrop_stallreq got=%b want=0", stallreq); end
    @(negedge clk);
    #1;
    n_checks++; if (inst !== 32'h0) begin n_errors++;
      $display("FAIL cedrop_inst got=%h want=0", inst); end
    n_checks++; if (mem_bus.mem_rd !== 1'b0) begin n_errors++;
      $display("FAIL cedrop_mem_rd got=%b want=0", mem_bus.mem_rd); end
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++;
      $display("FAIL cedrop_inst_valid got=%b want=0", inst_valid); end
    run_fetch(32'h0, 0, lat, waits, stalls);
    n_checks++; if (lat !== 5) begin n_errors++;
      $display("FAIL cedrop_refetch_latency got=%0d want=5", lat); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_errors++;
      $display("FAIL cedrop_refetch_inst got=%h want=00000013", inst); end
  endtask

  task automatic test_misaligned();
    drop_ce(1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pc = 32'h6;
      ce = 1'b1;
      #1;
      n_checks++; if (inst_misaligned !== 1'b1) begin n_errors++;
        $display("FAIL misaligned_flag c=%0d got=%b want=1", c, inst_misaligned); end
      n_checks++; if (stallreq !== 1'b0) begin n_errors++;
        $display("FAIL misaligned_stallreq c=%0d got=%b want=0", c, stallreq); end
      n_checks++; if (mem_bus.mem_rd !== 1'b0) begin n_errors++;
        $display("FAIL misaligned_mem_rd c=%0d got=%b want=0", c, mem_bus.mem_rd); end
      if (c > 0) begin
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++;
          $display("FAIL misaligned_valid c=%0d got=%b want=0", c, inst_valid); end
      end
    end
  endtask

  task automatic test_wrap();
    int lat, waits, stalls;
    drop_ce(1);
    run_fetch(32'hFFFF_FFFC, 25, lat, waits, stalls);
    n_checks++; if (lat !== 5 + waits) begin n_errors++;
      $display("FAIL wrap_latency got=%0d want=%0d", lat, 5 + waits); end
    n_checks++; if (inst !== word_at(32'hFFFF_FFFC)) begin n_errors++;
      $display("FAIL wrap_inst got=%h want=%h", inst, word_at(32'hFFFF_FFFC)); end
    for (int k = 0; k < addrs.size(); k++) begin
      n_checks++; if (addrs[k] !== 32'hFFFF_FFFC + 32'(k)) begin n_errors++;
        $display("FAIL wrap_addr[%0d] got=%h want=%h", k, addrs[k], 32'hFFFF_FFFC + k); end
    end
  endtask

  task automatic test_random();
    int lat, waits, stalls;
    logic [31:0] a;
    logic [31:0] prev;
    drop_ce(1);
    prev = 32'h1;
    for (int it = 0; it < 16; it++) begin
      if (it > 0 && $urandom_range(3) == 0) a = prev;
      else a = {24'h0, 6'($urandom_range(63)), 2'b00};
      run_fetch(a, 30, lat, waits, stalls);
      if (a == prev) begin
        n_checks++; if (lat !== 0) begin n_errors++;
          $display("FAIL rand_hit_latency it=%0d got=%0d want=0", it, lat); end
      end else begin
        n_checks++; if (lat !== 5 + waits) begin n_errors++;
          $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, lat, 5 + waits); end
        n_checks++; if (stalls !== lat) begin n_errors++;
          $display("FAIL rand_stalls it=%0d got=%0d want=%0d", it, stalls, lat); end
        n_checks++; if (addrs.size() !== 4) begin n_errors++;
          $display("FAIL rand_nreads it=%0d got=%0d want=4", it, addrs.size()); end
        for (int k = 0; k < addrs.size(); k++) begin
          n_checks++; if (addrs[k] !== a + 32'(k)) begin n_errors++;
            $display("FAIL rand_addr it=%0d k=%0d got=%h want=%h", it, k, addrs[k], a + k); end
        end
      end
      n_checks++; if (inst !== word_at(a)) begin n_errors++;
        $display("FAIL rand_inst it=%0d got=%h want=%h", it, inst, word_at(a)); end
      prev = a;
    end
  endtask

`ifdef INST_FETCH_PREFETCH_EN
  task automatic test_prefetch();
    int lat, waits, stalls;
    drop_ce(1);
    run_fetch(32'h0, 0, lat, waits, stalls);
    repeat (3) begin
      @(negedge clk);
      pc = 32'h0;
    end
    @(negedge clk);
    pc = 32'h4;
    #1;
    n_checks++; if (stallreq !== 1'b1) begin n_errors++;
      $display("FAIL pref_stall got=%b want=1", stallreq); end
    @(negedge clk);
    #1;
    n_checks++; if (!(inst_valid === 1'b1 && inst_pc === 32'h4)) begin n_errors++;
      $display("FAIL pref_deliver valid=%b pc=%h want 1/4", inst_valid, inst_pc); end
    n_checks++; if (inst !== word_at(32'h4)) begin n_errors++;
      $display("FAIL pref_inst got=%h want=%h", inst, word_at(32'h4)); end
    n_checks++; if (!(mem_bus.mem_rd === 1'b1 && mem_bus.mem_addr === 32'h8)) begin n_errors++;
      $display("FAIL pref_next rd=%b addr=%h want 1/8", mem_bus.mem_rd, mem_bus.mem_addr); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(255));
    mem[8'h40] = 8'hA5;
    test_reset();
    test_basic();
    test_wait_states();
    test_redirect();
    test_ce_drop();
    test_misaligned();
    test_wrap();
    test_random();
`ifdef INST_FETCH_PREFETCH_EN
    test_prefetch();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_port.md
# inst_fetch_port

Instruction-fetch responder between the PC register and a byte-wide instruction memory.
- Accepts the PC register's `pc`/`ce` request pair.
- Fetches the 32-bit little-endian word at `pc` as four byte reads and presents it as `inst`.
- Raises `stallreq` to the pipeline controller, which holds the PC, until the word for the current `pc` is valid.
- Sits in the IF stage, feeding the IF/ID latch.

## Interface
Parameters:
- `MEM_AW`, 32, width of the byte-memory address.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset (`RstEnable` = 1).
- `pc` input 32: requested instruction address, from the PC register.
- `ce` input 1: fetch enable, from the PC register; 0 = chip disabled.
- `inst` output 32: fetched instruction for `inst_pc`.
- `inst_pc` output 32: address of `inst`.
- `inst_valid` output 1: `inst` corresponds to the current `pc`.
- `inst_misaligned` output 1: `pc[1:0]` != 0 while `ce` = 1; combinational.
- `stallreq` output 1: stall request to the controller; combinational.
- `mem_addr` output MEM_AW: byte address.
- `mem_rd` output 1: read strobe.
- `mem_rdata` input 8: read data, sampled when `mem_ready` = 1.
- `mem_ready` input 1: read accepted and data valid this cycle.

## Operation
- State machine states: IDLE, FETCH, PREF. PREF exists only when the macro is defined.
- Registers:
  - `req_pc[31:0]`
  - `byte_cnt[1:0]`
  - `asm_word[31:0]`
  - `inst`, `inst_pc`, `inst_valid`
- Hit: `inst_valid` && `pc` == `inst_pc`.
- `stallreq` = `ce` && !hit && !`inst_misaligned`.

IDLE:
- If `ce` && !hit && !misaligned: latch `req_pc` <= `pc`, set `byte_cnt` <= 0, clear `inst_valid`, go to FETCH.

FETCH:
- Drive `mem_rd` = 1 and `mem_addr` = {`req_pc`[31:2], `byte_cnt`}.
- On `mem_ready`: write `asm_word[8*byte_cnt +: 8]` <= `mem_rdata`.
- On `mem_ready` with `byte_cnt` = 3:
  - `inst` <= assembled word, with the incoming byte in [31:24].
  - `inst_pc` <= `req_pc`, `inst_valid` <= 1.
  - Go to IDLE, or to PREF when configured.
- On `mem_ready` otherwise: `byte_cnt` += 1.
- `mem_ready` = 0: hold address and strobe, no state change.

Redirect:
- In any non-IDLE state, `ce` = 1 with `pc` != `req_pc` (and no prefetch match) aborts the read in flight. The data of an aborted read is discarded.
- Same cycle: `req_pc` <= `pc`, `byte_cnt` <= 0, stay in or enter FETCH.

Other rules:
- `ce` = 0 in any state:
  - Next state IDLE, `inst_valid` <= 0, `inst` <= 0, `mem_rd` = 0.
  - Not counted as a redirect.
- Misaligned `pc`: no fetch is issued, `stallreq` = 0, `inst_valid` stays 0. Trap handling is downstream.
- Address arithmetic wraps modulo 2^32. A next-sequential address of 0xFFFFFFFC + 4 = 0.
- Reset: state IDLE, `byte_cnt` = 0, `req_pc` = 0, `asm_word` = 0, `inst` = 0, `inst_pc` = 0, `inst_valid` = 0, `mem_rd` = 0, `mem_addr` = 0. Reset mid-fetch abandons the read; no byte is written.

## Timing
- Demand miss with `mem_ready` tied high:
  - `pc` presented in cycle N (IDLE): `stallreq` = 1.
  - Byte reads in cycles N+1 to N+4.
  - `inst_valid` = 1 and `stallreq` = 0 in cycle N+5.
  - Miss latency is 5 cycles plus the total `mem_ready` wait cycles.
- Hit: `stallreq` = 0 in the same cycle. Zero added latency.
- Redirect in cycle M: the first read of the new word is in cycle M+1 and `inst_valid` rises at M+5.
- `mem_addr`/`mem_rd` are registered and change only on `clk` edges.

## Configuration
Macro `INST_FETCH_PREFETCH_EN`.

Defined:
- Delivering a word at `inst_pc` = A moves the FSM to PREF, which fetches the word at A+4 into `pbuf[31:0]` and sets `pbuf_valid` when done.
- When `pc` becomes A+4 and `pbuf_valid` = 1: in the next cycle, `inst` <= `pbuf`, `inst_pc` <= A+4, `inst_valid` <= 1, `pbuf_valid` <= 0, and a prefetch of A+8 starts. `stallreq` is 1 for exactly one cycle.
- When `pc` becomes A+4 while PREF is in progress: PREF continues without restart and becomes the demand fetch. The word is delivered at prefetch completion.
- Any other `pc` change, or `ce` = 0: `pbuf_valid` <= 0 and the normal redirect rule applies.

Undefined:
- No PREF state and no `pbuf`.
- FSM returns to IDLE after every fill, and every new `pc` costs the full miss latency.

## Test plan
1. Reset, `ce` = 1, `pc` = 0x00000000, memory bytes 0..3 = 13,00,00,00, `mem_ready` = 1 -> `stallreq` 1 for cycles 0-4; `inst` = 0x00000013, `inst_valid` = 1 at cycle 5; `mem_addr` sequence 0, 1, 2, 3.
2. Same as 1, but `mem_ready` low for 2 cycles on byte 2 -> `inst_valid` at cycle 7; `mem_addr` holds 2 for 3 cycles.
3. `pc` changes 0x10 -> 0x40 after byte 1 of 0x10 is read -> bytes of 0x10 are discarded; reads resume at 0x40; `inst_pc` = 0x40; no `inst_valid` for 0x10.
4. `ce` dropped mid-fetch, then raised with `pc` = 0x0 -> `inst` = 0 and `mem_rd` = 0 while `ce` = 0; a fresh 5-cycle fetch of 0x0 follows.
5. `pc` = 0x6 with `ce` = 1 -> `inst_misaligned` = 1, `stallreq` = 0, `mem_rd` never asserted.
6. With `INST_FETCH_PREFETCH_EN`, sequential `pc` 0x0, 0x4 -> the 0x4 word is presented with a 1-cycle stall after the prefetch completes; `mem_addr` continues 8..11.
